// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit: geometry,
// halt opcode nibble, FSM state encoding and a saturating counter helper.
package fetch_pkg;

  localparam int          AW_DEF       = 8;
  localparam int          DW_DEF       = 16;
  localparam logic [3:0]  HALT_NIB_DEF = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: instruction ROM address/data, branch redirect and the
// valid/ready handoff to decode. master = fetch unit, slave = its environment.
interface instr_fetch_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic [AW-1:0] IMEM_A;
  logic [DW-1:0] IMEM_RD;
  logic          BR_TAKEN;
  logic [AW-1:0] BR_TARGET;
  logic [DW-1:0] INSTR;
  logic [AW-1:0] INSTR_PC;
  logic          VALID;
  logic          READY;
  logic          HALTED;

  modport master (
    output IMEM_A, INSTR, INSTR_PC, VALID, HALTED,
    input  IMEM_RD, BR_TAKEN, BR_TARGET, READY
  );

  modport slave (
    input  IMEM_A, INSTR, INSTR_PC, VALID, HALTED,
    output IMEM_RD, BR_TAKEN, BR_TARGET, READY
  );
endinterface

// File: rtl/fetch_pc.sv
// Program counter: reset load, redirect mux (highest priority) and
// increment that wraps naturally modulo 2^AW.
module fetch_pc #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_en,
  input  logic          br,
  input  logic [AW-1:0] br_target,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (br)
      pc_d = br_target;
    else if (inc_en)
      pc_d = pc_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the ROM address from the PC, registers the returned
// word for decode over VALID/READY, handles redirect and halt. Optional
// FETCH_PERF_EN adds saturating FETCH_CNT/STALL_CNT counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [3:0]    HALT_NIB = HALT_NIB_DEF
) (
  input  logic  CLK,
  input  logic  RST,
  instr_fetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] FETCH_CNT,
  output logic [15:0] STALL_CNT
`endif
);

  fetch_state_e  state_q, state_d;
  logic          valid_q, valid_d;
  logic          halted_q, halted_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic [AW-1:0] pc;
  logic          br, load, fetch;

  // Redirect is ignored in IDLE; a load slot exists in RUN whenever the
  // output register is empty or being consumed this edge.
  assign br    = bus.BR_TAKEN && (state_q != IDLE);
  assign load  = (state_q == RUN) && (!valid_q || bus.READY);
  assign fetch = load && !br;

  fetch_pc #(.AW(AW), .RESET_PC(RESET_PC)) u_pc (
    .clk       (CLK),
    .rst       (RST),
    .inc_en    (fetch),
    .br        (br),
    .br_target (bus.BR_TARGET),
    .pc        (pc)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (load) begin
          instr_d    = bus.IMEM_RD;
          instr_pc_d = pc;
          valid_d    = 1'b1;
          if (bus.IMEM_RD[DW-1 -: 4] == HALT_NIB) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
        end
      end
      HALT: begin
        if (valid_q && bus.READY)
          valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything; any handshake this edge still completes.
    if (br) begin
      state_d    = RUN;
      valid_d    = 1'b0;
      halted_d   = 1'b0;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign bus.IMEM_A   = pc;
  assign bus.INSTR    = instr_q;
  assign bus.INSTR_PC = instr_pc_q;
  assign bus.VALID    = valid_q;
  assign bus.HALTED   = halted_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch)
      fetch_cnt_d = sat_inc16(fetch_cnt_q);
    if ((state_q == RUN) && valid_q && !bus.READY)
      stall_cnt_d = sat_inc16(stall_cnt_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign STALL_CNT = stall_cnt_q;
`endif

endmodule
